// File: rtl/eth_rxfilter_pkg.sv
// Shared types and constants for the RX destination-address filter.
package eth_rxfilter_pkg;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      DA        = 3'd1,
      DECIDE    = 3'd2,
      WAIT_HASH = 3'd3,
      DONE      = 3'd4
   } rxfState_t;

   typedef enum logic [2:0] {
      MT_NONE    = 3'd0,
      MT_UCAST   = 3'd1,
      MT_MCAST   = 3'd2,
      MT_BCAST   = 3'd3,
      MT_PROMISC = 3'd4
   } matchType_t;

   localparam int DA_BYTES = 6;

   // Selects DA byte idx of a 48-bit MAC held in register order (byte 0 = MSB).
   function automatic logic [7:0] daByte(input logic [47:0] addr, input logic [2:0] idx);
      logic [7:0] b;
      case (idx)
         3'd0:    b = addr[47:40];
         3'd1:    b = addr[39:32];
         3'd2:    b = addr[31:24];
         3'd3:    b = addr[23:16];
         3'd4:    b = addr[15:8];
         3'd5:    b = addr[7:0];
         default: b = 8'h00;
      endcase
      return b;
   endfunction

endpackage

// File: rtl/eth_rxaddr_slot.sv
// One exact-match slot: running byte-wise comparison of the DA against a MAC.
module eth_rxaddr_slot
   import eth_rxfilter_pkg::*;
(
   input  logic        MRxClk,
   input  logic        Resetn,
   input  logic [47:0] MacAddr,
   input  logic [7:0]  RxByte,
   input  logic [2:0]  ByteIdx,
   input  logic        ByteValid,
   input  logic        Clear,
   input  logic        Enable,
   output logic        Match
);

   logic byteEq;

   assign byteEq = (RxByte == daByte(MacAddr, ByteIdx)) & Enable;

   // Flag restarts on byte 0 and is ANDed with every following byte compare.
   always_ff @(posedge MRxClk or negedge Resetn) begin
      if (!Resetn) begin
         Match <= 1'b0;
      end else if (Clear) begin
         Match <= 1'b0;
      end else if (ByteValid) begin
         if (ByteIdx == 3'd0)
            Match <= byteEq;
         else
            Match <= Match & byteEq;
      end
   end

endmodule

// File: rtl/eth_rxaddrfilter.sv
// RX destination-address filter: exact-match slots, multicast hash,
// broadcast and promiscuous controls, one registered decision per frame.
module eth_rxaddrfilter
   import eth_rxfilter_pkg::*;
#(
   parameter int NUM_MAC   = 4,
   parameter int HASH_BITS = 6,
   parameter int IDX_W     = (NUM_MAC > 1) ? $clog2(NUM_MAC) : 1
) (
   input  logic                    MRxClk,
   input  logic                    Resetn,
   input  logic                    RxStartFrm,
   input  logic                    StateDA,
   input  logic [7:0]              RxByte,
   input  logic                    RxByteValid,
   input  logic                    RxEndFrm,
   input  logic                    r_Pro,
   input  logic                    r_Bro,
   input  logic [48*NUM_MAC-1:0]   MacTable,
   input  logic [NUM_MAC-1:0]      MacEn,
   input  logic [2**HASH_BITS-1:0] HashTable,
   input  logic [HASH_BITS-1:0]    CrcHash,
   input  logic                    CrcHashGood,
   output logic                    FilterDone,
   output logic                    RxAddressInvalid,
   output logic                    Address_mismatch,
   output logic                    AddressMiss,
   output logic [2:0]              MatchType,
   output logic [IDX_W-1:0]        MatchIdx
);

   rxfState_t          state, stateNext;
   logic [2:0]         byteCnt;
   logic               stateDaQ;
   logic               bcastFlag, mcastFlag;
   logic               hashSeen, hashHit;
   logic [NUM_MAC-1:0] slotHit;
   logic               byteTake, lastByte, runtAbort;
   logic               hitNow;
   logic               anySlot;
   logic [IDX_W-1:0]   hitIdx;
   logic               decide, reject;
   matchType_t         typeNext;
   logic [IDX_W-1:0]   idxNext;

   assign byteTake  = (state == DA) & StateDA & RxByteValid & (byteCnt < 3'(DA_BYTES));
   assign lastByte  = byteTake & (byteCnt == 3'(DA_BYTES - 1));
   // A falling StateDA before the sixth byte means a runt: abandon silently.
   assign runtAbort = (state == DA) & stateDaQ & ~StateDA;
   // A hash pulse in the resolving cycle takes precedence over the latched value.
   assign hitNow    = CrcHashGood ? HashTable[CrcHash] : hashHit;

   genvar k;
   generate
      for (k = 0; k < NUM_MAC; k++) begin : gSlot
         eth_rxaddr_slot uSlot (
            .MRxClk   (MRxClk),
            .Resetn   (Resetn),
            .MacAddr  (MacTable[48*k +: 48]),
            .RxByte   (RxByte),
            .ByteIdx  (byteCnt),
            .ByteValid(byteTake),
            .Clear    (RxStartFrm),
            .Enable   (MacEn[k]),
            .Match    (slotHit[k])
         );
      end
   endgenerate

   // Lowest matching slot index wins.
   always_comb begin
      anySlot = |slotHit;
      hitIdx  = '0;
      for (int i = NUM_MAC - 1; i >= 0; i--) begin
         if (slotHit[i])
            hitIdx = IDX_W'(i);
      end
   end

   // Next-state and decision logic; rejects report MatchType NONE.
   always_comb begin
      stateNext = state;
      decide    = 1'b0;
      reject    = 1'b0;
      typeNext  = MT_NONE;
      idxNext   = '0;
      case (state)
         IDLE: ;
         DA: begin
            if (lastByte)
               stateNext = DECIDE;
            else if (RxEndFrm || runtAbort)
               stateNext = IDLE;
         end
         DECIDE: begin
            decide = 1'b1;
            if (r_Pro) begin
               typeNext = MT_PROMISC;
            end else if (bcastFlag) begin
               if (r_Bro) reject   = 1'b1;
               else       typeNext = MT_BCAST;
            end else if (anySlot) begin
               typeNext = MT_UCAST;
               idxNext  = hitIdx;
            end else if (mcastFlag && hashSeen) begin
               if (hashHit) typeNext = MT_MCAST;
               else         reject   = 1'b1;
            end else if (mcastFlag && !RxEndFrm) begin
               decide    = 1'b0;
               stateNext = WAIT_HASH;
            end else begin
               reject = 1'b1;
            end
            if (decide)
               stateNext = RxEndFrm ? IDLE : DONE;
         end
         WAIT_HASH: begin
            if (CrcHashGood || hashSeen) begin
               decide = 1'b1;
               if (hitNow) typeNext = MT_MCAST;
               else        reject   = 1'b1;
               stateNext = RxEndFrm ? IDLE : DONE;
            end else if (RxEndFrm) begin
               decide    = 1'b1;
               reject    = 1'b1;
               stateNext = IDLE;
            end
         end
         DONE: begin
            if (RxEndFrm)
               stateNext = IDLE;
         end
         default: stateNext = IDLE;
      endcase
      if (RxStartFrm) begin
         stateNext = DA;
         decide    = 1'b0;
         reject    = 1'b0;
      end
   end

   // FSM state register and StateDA history for runt detection.
   always_ff @(posedge MRxClk or negedge Resetn) begin
      if (!Resetn) begin
         state    <= IDLE;
         stateDaQ <= 1'b0;
      end else begin
         state    <= stateNext;
         stateDaQ <= StateDA;
      end
   end

   // Per-frame byte counter, broadcast/multicast flags and sticky hash capture.
   always_ff @(posedge MRxClk or negedge Resetn) begin
      if (!Resetn) begin
         byteCnt   <= '0;
         bcastFlag <= 1'b0;
         mcastFlag <= 1'b0;
         hashSeen  <= 1'b0;
         hashHit   <= 1'b0;
      end else if (RxStartFrm) begin
         byteCnt   <= '0;
         bcastFlag <= 1'b0;
         mcastFlag <= 1'b0;
         hashSeen  <= 1'b0;
         hashHit   <= 1'b0;
      end else begin
         if (byteTake) begin
            byteCnt   <= byteCnt + 3'd1;
            bcastFlag <= ((byteCnt == 3'd0) | bcastFlag) & (RxByte == 8'hFF);
            if (byteCnt == 3'd0)
               mcastFlag <= RxByte[0];
         end
         if (CrcHashGood && (state != IDLE)) begin
            hashSeen <= 1'b1;
            hashHit  <= HashTable[CrcHash];
         end
      end
   end

   // Decision outputs; a reject that coincides with frame end leaves the
   // invalid level low because the frame is already over.
   always_ff @(posedge MRxClk or negedge Resetn) begin
      if (!Resetn) begin
         FilterDone       <= 1'b0;
         Address_mismatch <= 1'b0;
         RxAddressInvalid <= 1'b0;
         AddressMiss      <= 1'b0;
         MatchType        <= 3'd0;
         MatchIdx         <= '0;
      end else begin
         FilterDone       <= decide;
         Address_mismatch <= decide & reject;
         if (RxEndFrm)
            RxAddressInvalid <= 1'b0;
         else if (decide && reject)
            RxAddressInvalid <= 1'b1;
         if (RxStartFrm) begin
            AddressMiss <= 1'b0;
            MatchType   <= 3'd0;
            MatchIdx    <= '0;
         end else if (decide) begin
            AddressMiss <= reject;
            MatchType   <= typeNext;
            MatchIdx    <= idxNext;
         end
      end
   end

endmodule

// File: tb/tb_eth_rxaddrfilter.sv
// Self-checking bench for eth_rxaddrfilter against a behavioural filter model.
module tb_eth_rxaddrfilter;

   localparam int NUM_MAC   = 4;
   localparam int HASH_BITS = 6;
   localparam int IDX_W     = 2;

   logic                    MRxClk = 1'b0;
   logic                    Resetn = 1'b0;
   logic                    RxStartFrm = 1'b0;
   logic                    StateDA = 1'b0;
   logic [7:0]              RxByte = 8'h00;
   logic                    RxByteValid = 1'b0;
   logic                    RxEndFrm = 1'b0;
   logic                    r_Pro = 1'b0;
   logic                    r_Bro = 1'b0;
   logic [48*NUM_MAC-1:0]   MacTable = '0;
   logic [NUM_MAC-1:0]      MacEn = '0;
   logic [2**HASH_BITS-1:0] HashTable = '0;
   logic [HASH_BITS-1:0]    CrcHash = '0;
   logic                    CrcHashGood = 1'b0;
   logic                    FilterDone;
   logic                    RxAddressInvalid;
   logic                    Address_mismatch;
   logic                    AddressMiss;
   logic [2:0]              MatchType;
   logic [IDX_W-1:0]        MatchIdx;

   int total = 0;
   int bad   = 0;
   logic [HASH_BITS-1:0] curHash = '0;

   eth_rxaddrfilter #(.NUM_MAC(NUM_MAC), .HASH_BITS(HASH_BITS), .IDX_W(IDX_W)) dut (
      .MRxClk(MRxClk), .Resetn(Resetn), .RxStartFrm(RxStartFrm), .StateDA(StateDA),
      .RxByte(RxByte), .RxByteValid(RxByteValid), .RxEndFrm(RxEndFrm),
      .r_Pro(r_Pro), .r_Bro(r_Bro), .MacTable(MacTable), .MacEn(MacEn),
      .HashTable(HashTable), .CrcHash(CrcHash), .CrcHashGood(CrcHashGood),
      .FilterDone(FilterDone), .RxAddressInvalid(RxAddressInvalid),
      .Address_mismatch(Address_mismatch), .AddressMiss(AddressMiss),
      .MatchType(MatchType), .MatchIdx(MatchIdx)
   );

   always #5 MRxClk = ~MRxClk;

   task automatic tick();
      @(posedge MRxClk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Filter rules applied to the whole 48-bit DA at once.
   task automatic model(input logic [47:0] da, output logic [2:0] t, output int idx,
                        output bit rej, output bit needHash);
      int found;
      t = 3'd0; idx = 0; rej = 1'b0; needHash = 1'b0; found = -1;
      for (int s = 0; s < NUM_MAC; s++)
         if (found < 0 && MacEn[s] && MacTable[48*s +: 48] == da) found = s;
      if (r_Pro) t = 3'd4;
      else if (da == 48'hFFFF_FFFF_FFFF) begin
         if (r_Bro) rej = 1'b1; else t = 3'd3;
      end else if (found >= 0) begin
         t = 3'd1; idx = found;
      end else if (da[40]) begin
         needHash = 1'b1;
         if (HashTable[curHash]) t = 3'd2; else rej = 1'b1;
      end else rej = 1'b1;
   endtask

   task automatic startFrm(input string tag);
      RxStartFrm = 1'b1;
      tick();
      RxStartFrm = 1'b0;
      chk({tag, ":start_miss"}, 32'(AddressMiss), 32'(0));
      chk({tag, ":start_type"}, 32'(MatchType), 32'(0));
   endtask

   task automatic sendDa(input logic [47:0] da, input string tag);
      StateDA = 1'b1;
      for (int i = 0; i < 6; i++) begin
         RxByte = da[47-8*i -: 8];
         RxByteValid = 1'b1;
         tick();
         chk({tag, ":early_done"}, 32'(FilterDone), 32'(0));
      end
      RxByteValid = 1'b0;
      StateDA = 1'b0;
   endtask

   task automatic endFrm(input bit expMiss, input string tag);
      RxEndFrm = 1'b1;
      tick();
      RxEndFrm = 1'b0;
      chk({tag, ":inv_clear"}, 32'(RxAddressInvalid), 32'(0));
      chk({tag, ":miss_hold"}, 32'(AddressMiss), 32'(expMiss));
   endtask

   task automatic chkDecision(input logic [2:0] t, input int idx, input bit rej, input string tag);
      chk({tag, ":done"}, 32'(FilterDone), 32'(1));
      chk({tag, ":mismatch"}, 32'(Address_mismatch), 32'(rej));
      chk({tag, ":invalid"}, 32'(RxAddressInvalid), 32'(rej));
      chk({tag, ":miss"}, 32'(AddressMiss), 32'(rej));
      if (!rej) chk({tag, ":type"}, 32'(MatchType), 32'(t));
      if (!rej && t == 3'd1) chk({tag, ":idx"}, 32'(MatchIdx), 32'(idx));
   endtask

   task automatic chkPulseEnd(input bit rej, input string tag);
      chk({tag, ":done_pulse"}, 32'(FilterDone), 32'(0));
      chk({tag, ":mism_pulse"}, 32'(Address_mismatch), 32'(0));
      chk({tag, ":inv_hold"}, 32'(RxAddressInvalid), 32'(rej));
   endtask

   // Full frame: start, DA, optional late hash (hashDly cycles after byte 6), end.
   task automatic runFrame(input logic [47:0] da, input int hashDly, input bit endEarly,
                           input string tag);
      logic [2:0] t; int idx; bit rej, needHash;
      CrcHash = curHash;
      model(da, t, idx, rej, needHash);
      startFrm(tag);
      sendDa(da, tag);
      if (!needHash) begin
         tick();
         chkDecision(t, idx, rej, tag);
         tick();
         chkPulseEnd(rej, tag);
         endFrm(rej, tag);
      end else begin
         tick();
         chk({tag, ":wait_nodone"}, 32'(FilterDone), 32'(0));
         for (int i = 0; i < hashDly - 2; i++) begin
            tick();
            chk({tag, ":wait_nodone"}, 32'(FilterDone), 32'(0));
         end
         if (endEarly) begin
            RxEndFrm = 1'b1;
            tick();
            RxEndFrm = 1'b0;
            chk({tag, ":eof_done"}, 32'(FilterDone), 32'(1));
            chk({tag, ":eof_mism"}, 32'(Address_mismatch), 32'(1));
            chk({tag, ":eof_miss"}, 32'(AddressMiss), 32'(1));
            CrcHashGood = 1'b1;
            tick();
            CrcHashGood = 1'b0;
            chk({tag, ":eof_nodup"}, 32'(FilterDone), 32'(0));
            chk({tag, ":eof_misshold"}, 32'(AddressMiss), 32'(1));
         end else begin
            CrcHashGood = 1'b1;
            tick();
            CrcHashGood = 1'b0;
            chkDecision(t, idx, rej, tag);
            tick();
            chkPulseEnd(rej, tag);
            endFrm(rej, tag);
         end
      end
   endtask

   task automatic chkAllZero(input string tag);
      chk({tag, ":done0"}, 32'(FilterDone), 32'(0));
      chk({tag, ":inv0"}, 32'(RxAddressInvalid), 32'(0));
      chk({tag, ":mism0"}, 32'(Address_mismatch), 32'(0));
      chk({tag, ":miss0"}, 32'(AddressMiss), 32'(0));
      chk({tag, ":type0"}, 32'(MatchType), 32'(0));
      chk({tag, ":idx0"}, 32'(MatchIdx), 32'(0));
   endtask

   initial begin
      logic [47:0] da;
      int kind;

      // Reset state
      repeat (3) tick();
      chkAllZero("reset");
      Resetn = 1'b1;
      tick();

      // Exact-match slot 2
      MacTable = '0;
      MacTable[48*0 +: 48] = 48'h0200_0000_0001;
      MacTable[48*1 +: 48] = 48'h0200_0000_0002;
      MacTable[48*2 +: 48] = 48'h0011_2233_4455;
      MacTable[48*3 +: 48] = 48'h0200_0000_0004;
      MacEn = 4'b0100;
      runFrame(48'h0011_2233_4455, 0, 1'b0, "slot2");

      // Slot enable and lowest-index priority
      MacTable[48*1 +: 48] = 48'h0A1B_2C3D_4E5F;
      MacTable[48*3 +: 48] = 48'h0A1B_2C3D_4E5F;
      MacEn = 4'b1000;
      runFrame(48'h0A1B_2C3D_4E5F, 0, 1'b0, "slot3");
      MacEn = 4'b1010;
      runFrame(48'h0A1B_2C3D_4E5F, 0, 1'b0, "slot1low");
      MacEn = 4'b0000;
      runFrame(48'h0A1B_2C3D_4E5F, 0, 1'b0, "slotoff");
      runFrame(48'h0011_2233_4455, 0, 1'b0, "slotoff2");

      // Broadcast / promiscuous
      r_Bro = 1'b0; r_Pro = 1'b0;
      runFrame(48'hFFFF_FFFF_FFFF, 0, 1'b0, "bcast");
      r_Bro = 1'b1;
      runFrame(48'hFFFF_FFFF_FFFF, 0, 1'b0, "bcastrej");
      r_Pro = 1'b1;
      runFrame(48'hFFFF_FFFF_FFFF, 0, 1'b0, "promisc");
      r_Pro = 1'b0; r_Bro = 1'b0;

      // Late multicast hash
      curHash = 6'd37;
      HashTable = '0;
      HashTable[37] = 1'b1;
      runFrame(48'h0100_5E00_0001, 4, 1'b0, "hashhit");
      HashTable[37] = 1'b0;
      HashTable[36] = 1'b1;
      runFrame(48'h0100_5E00_0001, 4, 1'b0, "hashmiss");
      HashTable[37] = 1'b1;
      runFrame(48'h0100_5E00_0001, 4, 1'b1, "hasheof");

      // Runt abort after 3 bytes
      startFrm("runt");
      StateDA = 1'b1;
      for (int i = 0; i < 3; i++) begin
         RxByte = 8'h55; RxByteValid = 1'b1;
         tick();
      end
      RxByteValid = 1'b0;
      StateDA = 1'b0;
      for (int i = 0; i < 5; i++) begin
         if (i == 2) CrcHashGood = 1'b1;
         tick();
         CrcHashGood = 1'b0;
         chkAllZero("runt");
      end
      endFrm(1'b0, "runt");

      // Reset after a reject decision clears held outputs
      startFrm("rstrej");
      sendDa(48'h0A00_0000_0099, "rstrej");
      tick();
      chk("rstrej:pre_inv", 32'(RxAddressInvalid), 32'(1));
      chk("rstrej:pre_miss", 32'(AddressMiss), 32'(1));
      #2 Resetn = 1'b0;
      #1 chkAllZero("rstrej");
      tick();
      Resetn = 1'b1;

      // Reset while waiting for the hash
      startFrm("rsthash");
      sendDa(48'h0100_5E00_0001, "rsthash");
      tick();
      tick();
      #2 Resetn = 1'b0;
      #1 chkAllZero("rsthash");
      tick();
      Resetn = 1'b1;
      CrcHashGood = 1'b1;
      tick();
      CrcHashGood = 1'b0;
      tick();
      chk("rsthash:idle_nodone", 32'(FilterDone), 32'(0));
      runFrame(48'h0100_5E00_0001, 3, 1'b0, "afterrst");

      // Randomised frames, back to back
      for (int n = 0; n < 30; n++) begin
         for (int s = 0; s < NUM_MAC; s++)
            MacTable[48*s +: 48] = 48'({$urandom, $urandom});
         MacEn     = 4'($urandom);
         r_Pro     = ($urandom_range(0, 7) == 0);
         r_Bro     = 1'($urandom);
         HashTable = {$urandom, $urandom};
         curHash   = 6'($urandom);
         kind      = $urandom_range(0, 4);
         case (kind)
            0: da = 48'hFFFF_FFFF_FFFF;
            1: da = MacTable[48*$urandom_range(0, NUM_MAC-1) +: 48];
            2: begin da = 48'({$urandom, $urandom}); da[40] = 1'b1; end
            3: begin da = 48'({$urandom, $urandom}); da[40] = 1'b0; end
            default: da = 48'h0100_5E00_0001;
         endcase
         runFrame(da, $urandom_range(2, 6), ($urandom_range(0, 5) == 0), "rand");
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
